dmem_arbiter: RTL and testbench

Shares the single-port data memory between the CPU datapath and a DMA/coprocessor requester. The DMA side gains memory ownership by asserting hold to the main decoder and waiting for holdACK. A burst limit and an ack timeout stop the DMA side from starving the CPU or hanging. The block sits between the CPU memory port, the DMA engine and dmem.

---
 rtl/dmem_arbiter_if.sv | 42 ++++
 rtl/dmem_arbiter.sv | 117 +++++++++++
 tb/tb_dmem_arbiter.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - CPU, DMA and dmem port bundle for the data memory arbiter.
interface dmem_arbiter_if #(
  parameter int wide = 32
);
  logic            cpu_we;
  logic [31:0]     cpu_addr;
  logic [wide-1:0] cpu_wd;
  logic [wide-1:0] cpu_rd;

  logic            dma_req;
  logic            dma_we;
  logic [31:0]     dma_addr;
  logic [wide-1:0] dma_wd;
  logic            dma_gnt;
  logic [wide-1:0] dma_rd;
  logic            dma_valid;
  logic            dma_err;

  logic            hold;
  logic            holdACK;

  logic            mem_we;
  logic [31:0]     mem_addr;
  logic [wide-1:0] mem_d;
  logic [wide-1:0] mem_q;

  modport slave (
    input  cpu_we, cpu_addr, cpu_wd,
    input  dma_req, dma_we, dma_addr, dma_wd,
    input  holdACK, mem_q,
    output cpu_rd, dma_gnt, dma_rd, dma_valid, dma_err,
    output hold, mem_we, mem_addr, mem_d
  );

  modport master (
    output cpu_we, cpu_addr, cpu_wd,
    output dma_req, dma_we, dma_addr, dma_wd,
    output holdACK, mem_q,
    input  cpu_rd, dma_gnt, dma_rd, dma_valid, dma_err,
    input  hold, mem_we, mem_addr, mem_d
  );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - single-port dmem sharing between CPU and DMA via hold/holdACK.
module dmem_arbiter #(
  parameter int wide        = 32,
  parameter int max_burst   = 4,
  parameter int ack_timeout = 16
) (
  input  logic          clk,
  input  logic          rst,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ_HOLD = 2'd1,
    DMA      = 2'd2,
    RELEASE  = 2'd3
  } state_e;

  localparam logic [7:0] BURST_LAST = 8'(max_burst);
  localparam logic [7:0] WAIT_LAST  = 8'(ack_timeout - 1);

  state_e          state_q, state_d;
  logic [7:0]      wait_q, wait_d;
  logic [7:0]      burst_q, burst_d;
  logic            hold_q, gnt_q, valid_q, err_q, err_d;
  logic [wide-1:0] rd_q;
  logic            access;

  function automatic logic [7:0] sat_inc(input logic [7:0] x);
    return (x == 8'hFF) ? x : x + 8'd1;
  endfunction

  assign access = (state_q == DMA) && bus.dma_req;

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    burst_d = burst_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.dma_req) begin
          state_d = REQ_HOLD;
          wait_d  = 8'd0;
        end
      end
      REQ_HOLD: begin
        wait_d = sat_inc(wait_q);
        // A late acknowledge landing on the timeout cycle still wins the grant.
        if (bus.holdACK) begin
          state_d = DMA;
          burst_d = 8'd0;
        end else if (!bus.dma_req) begin
          state_d = RELEASE;
        end else if (wait_q == WAIT_LAST) begin
          state_d = RELEASE;
          err_d   = 1'b1;
        end
      end
      DMA: begin
        if (bus.dma_req) begin
          burst_d = sat_inc(burst_q);
          if (burst_d == BURST_LAST) state_d = RELEASE;
        end else begin
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (!bus.holdACK) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wait_q  <= 8'd0;
      burst_q <= 8'd0;
      hold_q  <= 1'b0;
      gnt_q   <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      burst_q <= burst_d;
      hold_q  <= (state_d == REQ_HOLD) || (state_d == DMA);
      gnt_q   <= (state_d == DMA);
      valid_q <= access;
      err_q   <= err_d;
      if (access) rd_q <= bus.mem_q;
    end
  end

  always_comb begin
    if (state_q == DMA) begin
      bus.mem_addr = bus.dma_addr;
      bus.mem_d    = bus.dma_wd;
      bus.mem_we   = bus.dma_we & bus.dma_req;
    end else begin
      bus.mem_addr = bus.cpu_addr;
      bus.mem_d    = bus.cpu_wd;
      bus.mem_we   = bus.cpu_we;
    end
    if (rst) bus.mem_we = 1'b0;
  end

  assign bus.cpu_rd    = bus.mem_q;
  assign bus.hold      = hold_q;
  assign bus.dma_gnt   = gnt_q;
  assign bus.dma_valid = valid_q;
  assign bus.dma_err   = err_q;
  assign bus.dma_rd    = rd_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter with a dmem model and read-data scoreboard.
module tb_dmem_arbiter;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.wide(W)) bus();

  dmem_arbiter #(.wide(W), .max_burst(4), .ack_timeout(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] mem [0:255];
  assign bus.mem_q = mem[bus.mem_addr[9:2]];
  always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr[9:2]] <= bus.mem_d;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Expected DMA read data: memory content at the address of each granted access.
  logic [31:0] sb_q [$];
  always @(negedge clk) begin
    if (bus.dma_valid) begin
      check_eq("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
      if (sb_q.size() > 0) check_eq("dma_rd", bus.dma_rd, sb_q.pop_front());
    end
    if (!rst && bus.dma_gnt && bus.dma_req) sb_q.push_back(mem[bus.dma_addr[9:2]]);
  end

  int first_hold, first_gnt, first_valid, first_err;
  int hold_cnt, we_cnt, err_cnt, valid_cnt, gnt_err, grants, min_gap, gap;
  int first_burst, acc_in_grant, cpu_ok, rst_we, hold_run;
  logic [31:0] hold_after_rst, valid_after_rst, rd_after_rst;
  logic gnt_prev;

  // ack_lat: decoder raises holdACK once hold has been seen for ack_lat cycles.
  task automatic run_dma(input bit we, input logic [31:0] base, input int nacc, input int req_lim,
                         input int ack_lat, input int ncyc, input int rst_cyc);
    int n = 0;
    first_hold = -1; first_gnt = -1; first_valid = -1; first_err = -1;
    hold_cnt = 0; we_cnt = 0; err_cnt = 0; valid_cnt = 0; gnt_err = 0; grants = 0;
    min_gap = 1000; gap = 0; first_burst = -1; acc_in_grant = 0; cpu_ok = 0; rst_we = 0;
    hold_run = 0; gnt_prev = 1'b0;
    hold_after_rst = '1; valid_after_rst = '1; rd_after_rst = '1;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk); #1;
      rst          = (c == rst_cyc);
      bus.holdACK  = (hold_run >= ack_lat);
      bus.dma_req  = (n < nacc) && (c < req_lim);
      bus.dma_we   = we;
      bus.dma_addr = base + 32'(n * 4);
      bus.dma_wd   = 32'hA500_0000 + 32'(n);
      @(negedge clk);
      if (bus.hold) begin
        hold_cnt++; hold_run++;
        if (first_hold < 0) first_hold = c;
      end else begin
        hold_run = 0;
      end
      if (bus.dma_gnt && first_gnt < 0) first_gnt = c;
      if (bus.dma_valid) begin
        valid_cnt++;
        if (first_valid < 0) first_valid = c;
      end
      if (bus.dma_err) begin
        err_cnt++;
        if (first_err < 0) first_err = c;
      end
      if (bus.dma_err && bus.dma_gnt) gnt_err++;
      if (bus.mem_we && bus.dma_gnt) we_cnt++;
      if (rst && bus.mem_we) rst_we++;
      if (rst_cyc >= 0 && c == rst_cyc + 1) begin
        hold_after_rst  = 32'(bus.hold);
        valid_after_rst = 32'(bus.dma_valid);
        rd_after_rst    = bus.dma_rd;
      end
      if (!rst && !bus.dma_gnt && bus.mem_addr == bus.cpu_addr && bus.mem_we == bus.cpu_we) cpu_ok++;
      if (bus.dma_gnt && !gnt_prev) begin
        grants++;
        acc_in_grant = 0;
        if (grants > 1 && gap < min_gap) min_gap = gap;
      end
      if (!bus.dma_gnt && gnt_prev && first_burst < 0) first_burst = acc_in_grant;
      if (bus.dma_gnt) gap = 0; else gap++;
      if (bus.dma_gnt && bus.dma_req && !rst) begin
        acc_in_grant++;
        n++;
      end
      gnt_prev = bus.dma_gnt;
    end
    rst = 1'b0; bus.dma_req = 1'b0; bus.holdACK = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    bus.cpu_we = 1'b1; bus.cpu_addr = 32'h40; bus.cpu_wd = 32'hDEAD_BEEF;
    bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_addr = 32'h0; bus.dma_wd = 32'h0;
    bus.holdACK = 1'b0;

    // Reset state, CPU store suppressed during reset
    repeat (2) @(negedge clk);
    check_eq("rst_hold",   32'(bus.hold),      32'd0);
    check_eq("rst_gnt",    32'(bus.dma_gnt),   32'd0);
    check_eq("rst_valid",  32'(bus.dma_valid), 32'd0);
    check_eq("rst_err",    32'(bus.dma_err),   32'd0);
    check_eq("rst_dma_rd", bus.dma_rd,         32'd0);
    check_eq("rst_mem_we", 32'(bus.mem_we),    32'd0);

    // CPU store with no DMA
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check_eq("cpu_mem_we",   32'(bus.mem_we), 32'd1);
    check_eq("cpu_mem_addr", bus.mem_addr,    32'h40);
    check_eq("cpu_mem_d",    bus.mem_d,       32'hDEAD_BEEF);
    check_eq("cpu_hold",     32'(bus.hold),   32'd0);
    @(posedge clk); #1; bus.cpu_we = 1'b0;
    @(negedge clk);
    check_eq("cpu_rd",  bus.cpu_rd, 32'hDEAD_BEEF);
    check_eq("cpu_mem", mem[16],    32'hDEAD_BEEF);

    // Single DMA read of 0x80, decoder acks one cycle after seeing hold
    mem[32] = 32'h1234_5678;
    run_dma(1'b0, 32'h80, 1, 100, 1, 8, -1);
    check_eq("rd_first_hold",  32'(first_hold),  32'd1);
    check_eq("rd_first_gnt",   32'(first_gnt),   32'd3);
    check_eq("rd_first_valid", 32'(first_valid), 32'd4);
    check_eq("rd_valid_cnt",   32'(valid_cnt),   32'd1);
    check_eq("rd_err_cnt",     32'(err_cnt),     32'd0);

    // Six writes against a burst limit of four
    for (int i = 0; i < 6; i++) mem[64 + i] = 32'h1000 + 32'(i);
    run_dma(1'b1, 32'h100, 6, 100, 1, 20, -1);
    check_eq("burst_we_cnt",  32'(we_cnt),      32'd6);
    check_eq("burst_first",   32'(first_burst), 32'd4);
    check_eq("burst_grants",  32'(grants),      32'd2);
    check_eq("burst_gap",     32'(min_gap),     32'd5);
    check_eq("burst_valid",   32'(valid_cnt),   32'd6);
    for (int i = 0; i < 6; i++) check_eq("burst_mem", mem[64 + i], 32'hA500_0000 + 32'(i));

    // holdACK never arrives: timeout after 16 hold cycles, CPU keeps working
    bus.cpu_we = 1'b1; bus.cpu_addr = 32'h44; bus.cpu_wd = 32'hC0FF_EE01;
    run_dma(1'b0, 32'h180, 1, 100, 1000, 19, -1);
    bus.cpu_we = 1'b0;
    check_eq("tmo_hold_cnt",  32'(hold_cnt),  32'd16);
    check_eq("tmo_err_cnt",   32'(err_cnt),   32'd1);
    check_eq("tmo_first_err", 32'(first_err), 32'd17);
    check_eq("tmo_no_gnt",    32'(first_gnt), 32'hFFFF_FFFF);
    check_eq("tmo_gnt_err",   32'(gnt_err),   32'd0);
    check_eq("tmo_cpu_ok",    32'(cpu_ok),    32'd19);
    check_eq("tmo_cpu_mem",   mem[17],        32'hC0FF_EE01);

    // Acknowledge on the timeout cycle: grant wins, no error
    mem[33] = 32'h8765_4321;
    run_dma(1'b0, 32'h84, 1, 100, 15, 24, -1);
    check_eq("race_first_gnt",   32'(first_gnt),   32'd17);
    check_eq("race_err_cnt",     32'(err_cnt),     32'd0);
    check_eq("race_first_valid", 32'(first_valid), 32'd18);

    // Reset during the second write of a burst
    for (int i = 0; i < 4; i++) mem[128 + i] = 32'h2000 + 32'(i);
    run_dma(1'b1, 32'h200, 4, 5, 1, 10, 4);
    check_eq("mrst_rst_we",  32'(rst_we),     32'd0);
    check_eq("mrst_we_cnt",  32'(we_cnt),     32'd1);
    check_eq("mrst_hold",    hold_after_rst,  32'd0);
    check_eq("mrst_valid",   valid_after_rst, 32'd0);
    check_eq("mrst_dma_rd",  rd_after_rst,    32'd0);
    check_eq("mrst_valid_n", 32'(valid_cnt),  32'd1);
    check_eq("mrst_mem0",    mem[128],        32'hA500_0000);
    check_eq("mrst_mem1",    mem[129],        32'h2001);

    // dma_req withdrawn while waiting for holdACK
    run_dma(1'b0, 32'h180, 1, 3, 1000, 8, -1);
    check_eq("drop_hold_cnt", 32'(hold_cnt),  32'd3);
    check_eq("drop_err_cnt",  32'(err_cnt),   32'd0);
    check_eq("drop_valid",    32'(valid_cnt), 32'd0);
    check_eq("drop_no_gnt",   32'(first_gnt), 32'hFFFF_FFFF);

    check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
